reg_to_axis_frame: RTL and testbench
====================================

Name: reg_to_axis_frame

Overview:
Parametrised successor to the free-running register-to-stream adapter. Snapshots NUM_CH parallel register channels coherently and serialises them as one AXI-stream frame (one beat per channel, channel index on tuser, tlast on the final beat) with full tvalid/tready handshake. Frames are launched continuously, on any input change, or on an external trigger. Sits between control/status register banks and DMA or stream-consumer logic in the Zynq fabric.

Parameters:
DIN_WIDTH, 16, width of one channel and of m_axis_tdata
NUM_CH, 4, channels per frame (1..256)
CH_BITS, derived, max(1, clog2(NUM_CH)); width of m_axis_tuser; not user-set

Ports:
aclk  in  1  stream clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
data_in  in  NUM_CH*DIN_WIDTH  channel k at bits [k*DIN_WIDTH +: DIN_WIDTH]
mode  in  2  0=continuous, 1=on-change, 2=on-trigger, 3=disabled
trigger  in  1  single-cycle launch request (mode 2)
m_axis_tdata  out  DIN_WIDTH  current channel word
m_axis_tuser  out  CH_BITS  current channel index
m_axis_tlast  out  1  high on beat NUM_CH-1
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  consumer ready
frame_count  out  16  frames completed, wraps 0xFFFF->0
overrun  out  1  sticky: trigger lost

Behaviour:
- Reset: tvalid=0, tdata=0, tuser=0, tlast=0, frame_count=0, overrun=0, state IDLE, last_sent snapshot=0, trig_pending=0, first_flag=1.
- States: IDLE, SEND.
- IDLE launch condition (evaluated every cycle): mode 0 always; mode 1 when data_in != last_sent or first_flag; mode 2 when trigger or trig_pending; mode 3 never.
- On launch at edge n: snapshot <= data_in, last_sent <= data_in, first_flag<=0, trig_pending<=0, ch<=0, state<=SEND; cycle n+1 presents tvalid=1, tdata=channel 0, tuser=0, tlast=(NUM_CH==1).
- SEND: outputs stable while tvalid & !tready (AXI rule, no change to tdata/tuser/tlast). On tvalid&tready with ch<NUM_CH-1: ch++, next beat next cycle, no bubble. On accept of last beat: tvalid<=0, frame_count++, state<=IDLE.
- Minimum one IDLE cycle between frames (continuous mode yields NUM_CH beats then 1 gap when tready held high).
- Data_in changes during SEND do not affect the frame in flight (snapshot only).
- mode sampled only in IDLE; mode change during SEND takes effect after the frame.
- trigger during SEND, or in IDLE when mode!=2: if mode==2 and trig_pending==0 then trig_pending<=1; if mode==2 and trig_pending==1 then overrun<=1. Triggers in other modes ignored.
- trigger in IDLE with mode 2 launches immediately; simultaneous trig_pending has no extra effect.
- NUM_CH==1: every beat has tlast=1, tuser=0.
- Reset mid-frame: frame abandoned, tvalid drops next cycle, all state to reset values.

Decomposition:
- Shared package: mode encoding constants (MODE_CONT=0, MODE_CHANGE=1, MODE_TRIG=2, MODE_OFF=3), state encoding, clog2 function.
- One natural sub-module: reg_to_axis_launch (mode decode, change compare, trigger pending/overrun), producing a single launch pulse to the serialiser FSM.

Test Plan:
- Reset, mode=0, NUM_CH=4, data_in={0x0004,0x0003,0x0002,0x0001}, tready=1 -> beats 0x0001..0x0004, tuser 0..3, tlast on 4th, 1 idle cycle, repeat; frame_count increments per frame.
- Mode 0, tready low for 5 cycles on beat 2 -> tvalid held, tdata/tuser/tlast stable; data_in changed meanwhile does not alter frame.
- Mode 1: first frame after reset even with data_in=0; hold data -> no further frames; change channel 3 only -> exactly one new frame with new value.
- Mode 2: trigger pulse -> one frame, tvalid at next cycle; second trigger mid-frame -> one back-to-back frame after 1 idle cycle; third trigger while pending -> overrun=1 and stays 1.
- Mode 3 -> tvalid never asserts for 100 cycles; mode change to 0 during SEND not applied until frame end.
- Reset asserted on beat 1 with tready=0 -> tvalid=0 next cycle, frame_count=0, overrun=0, fresh frame in mode 1 after release.

Source files
------------

// File: rtl/reg_to_axis_frame_pkg.sv
// Shared definitions for the register-bank to AXI-stream frame adapter.
package reg_to_axis_frame_pkg;

   localparam logic [1:0] MODE_CONT   = 2'd0;
   localparam logic [1:0] MODE_CHANGE = 2'd1;
   localparam logic [1:0] MODE_TRIG   = 2'd2;
   localparam logic [1:0] MODE_OFF    = 2'd3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // Channel-index width; a single channel still needs a 1-bit tuser.
   function automatic int unsigned ch_bits(input int unsigned n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/reg_to_axis_launch.sv
// Frame launch decision: mode decode, change detect, trigger pending and overrun.
module reg_to_axis_launch
   import reg_to_axis_frame_pkg::*;
#(
   parameter int unsigned DATA_W = 64
)(
   input  logic              aclk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in_i,
   input  logic [1:0]        mode_i,
   input  logic              trigger_i,
   input  logic              idle_i,
   output logic              launch_c,
   output logic              overrun_o
);

   logic [DATA_W-1:0] last_sent_q, last_sent_d;
   logic              first_q, first_d;
   logic              pend_q, pend_d;
   logic              overrun_q, overrun_d;
   logic              launch;

   always_ff @(posedge aclk) begin
      if (reset) begin
         last_sent_q <= '0;
         first_q     <= 1'b1;
         pend_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         last_sent_q <= last_sent_d;
         first_q     <= first_d;
         pend_q      <= pend_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      last_sent_d = last_sent_q;
      first_d     = first_q;
      pend_d      = pend_q;
      overrun_d   = overrun_q;
      launch      = 1'b0;
      if (idle_i) begin
         case (mode_i)
            MODE_CONT:   launch = 1'b1;
            MODE_CHANGE: launch = (data_in_i != last_sent_q) || first_q;
            MODE_TRIG:   launch = trigger_i || pend_q;
            default:     launch = 1'b0;
         endcase
      end
      // Triggers that cannot launch now are queued once; a second one is lost.
      if (launch) begin
         last_sent_d = data_in_i;
         first_d     = 1'b0;
         pend_d      = 1'b0;
      end else if (trigger_i && !idle_i && (mode_i == MODE_TRIG)) begin
         if (pend_q) overrun_d = 1'b1;
         else        pend_d    = 1'b1;
      end
   end

   assign launch_c  = launch;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/reg_to_axis_frame.sv
// Snapshots NUM_CH register channels and serialises them as one AXI-stream frame.
module reg_to_axis_frame
   import reg_to_axis_frame_pkg::*;
#(
   parameter  int unsigned DIN_WIDTH = 16,
   parameter  int unsigned NUM_CH    = 4,
   localparam int unsigned CH_BITS   = ch_bits(NUM_CH)
)(
   input  logic                        aclk,
   input  logic                        reset,
   input  logic [NUM_CH*DIN_WIDTH-1:0] data_in,
   input  logic [1:0]                  mode,
   input  logic                        trigger,
   output logic [DIN_WIDTH-1:0]        m_axis_tdata,
   output logic [CH_BITS-1:0]          m_axis_tuser,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [15:0]                 frame_count,
   output logic                        overrun
);

   localparam int unsigned        BUS_W   = NUM_CH * DIN_WIDTH;
   localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);

   logic [0:0]           state_q, state_d;
   logic [CH_BITS-1:0]   ch_q, ch_d, ch_nxt;
   logic [BUS_W-1:0]     snap_q, snap_d;
   logic [DIN_WIDTH-1:0] tdata_q, tdata_d;
   logic [CH_BITS-1:0]   tuser_q, tuser_d;
   logic                 tlast_q, tlast_d;
   logic                 tvalid_q, tvalid_d;
   logic [15:0]          fcnt_q, fcnt_d;
   logic                 launch_c;

   reg_to_axis_launch #(.DATA_W(BUS_W)) u_launch (
      .aclk      (aclk),
      .reset     (reset),
      .data_in_i (data_in),
      .mode_i    (mode),
      .trigger_i (trigger),
      .idle_i    (state_q == ST_IDLE),
      .launch_c  (launch_c),
      .overrun_o (overrun)
   );

   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ch_q     <= '0;
         snap_q   <= '0;
         tdata_q  <= '0;
         tuser_q  <= '0;
         tlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
         fcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         snap_q   <= snap_d;
         tdata_q  <= tdata_d;
         tuser_q  <= tuser_d;
         tlast_q  <= tlast_d;
         tvalid_q <= tvalid_d;
         fcnt_q   <= fcnt_d;
      end
   end

   assign ch_nxt = ch_q + CH_BITS'(1);

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      snap_d   = snap_q;
      tdata_d  = tdata_q;
      tuser_d  = tuser_q;
      tlast_d  = tlast_q;
      tvalid_d = tvalid_q;
      fcnt_d   = fcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (launch_c) begin
               snap_d   = data_in;
               ch_d     = '0;
               tdata_d  = data_in[DIN_WIDTH-1:0];
               tuser_d  = '0;
               tlast_d  = (NUM_CH == 1);
               tvalid_d = 1'b1;
               state_d  = ST_SEND;
            end
         end
         default: begin
            // Beat registers only move on acceptance, keeping the AXI hold rule.
            if (m_axis_tready) begin
               if (ch_q == LAST_CH) begin
                  tvalid_d = 1'b0;
                  fcnt_d   = fcnt_q + 16'd1;
                  state_d  = ST_IDLE;
               end else begin
                  ch_d    = ch_nxt;
                  tdata_d = DIN_WIDTH'(snap_q >> (int'(ch_nxt) * DIN_WIDTH));
                  tuser_d = ch_nxt;
                  tlast_d = (ch_nxt == LAST_CH);
               end
            end
         end
      endcase
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tvalid = tvalid_q;
   assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_reg_to_axis_frame.sv
// Directed and random stimulus against a beat-queue reference model.
module tb_reg_to_axis_frame;

   localparam int unsigned W  = 16;
   localparam int unsigned NC = 4;

   typedef struct {
      logic [15:0] d;
      logic [1:0]  u;
      logic        l;
   } beat_t;

   logic          aclk = 1'b0;
   logic          reset = 1'b1;
   logic [63:0]   data_in = '0;
   logic [1:0]    mode = 2'd3;
   logic          trigger = 1'b0;
   logic          m_axis_tready = 1'b1;
   logic [15:0]   m_axis_tdata;
   logic [1:0]    m_axis_tuser;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic [15:0]   frame_count;
   logic          overrun;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model: the frame in flight is just a queue of remaining beats.
   beat_t       exp_q[$];
   logic [63:0] m_last;
   bit          m_first, m_pend, m_ovr, m_just_reset;
   logic [15:0] m_fc;

   reg_to_axis_frame #(.DIN_WIDTH(W), .NUM_CH(NC)) dut (
      .aclk          (aclk),
      .reset         (reset),
      .data_in       (data_in),
      .mode          (mode),
      .trigger       (trigger),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .frame_count   (frame_count),
      .overrun       (overrun)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      beat_t b;
      bit    go;
      m_just_reset = 1'b0;
      if (reset) begin
         exp_q.delete();
         m_last = '0; m_first = 1'b1; m_pend = 1'b0; m_ovr = 1'b0; m_fc = '0;
         m_just_reset = 1'b1;
      end else if (exp_q.size() != 0) begin
         if (m_axis_tready) begin
            b = exp_q.pop_front();
            if (b.l) m_fc = m_fc + 16'd1;
         end
         if (trigger && mode == 2'd2) begin
            if (m_pend) m_ovr = 1'b1;
            else        m_pend = 1'b1;
         end
      end else begin
         case (mode)
            2'd0:    go = 1'b1;
            2'd1:    go = (data_in != m_last) || m_first;
            2'd2:    go = trigger || m_pend;
            default: go = 1'b0;
         endcase
         if (go) begin
            for (int k = 0; k < int'(NC); k++)
               exp_q.push_back('{data_in[k*16 +: 16], 2'(k), (k == int'(NC) - 1)});
            m_last = data_in; m_first = 1'b0; m_pend = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("tdata", 32'(m_axis_tdata), 32'(exp_q[0].d));
         chk("tuser", 32'(m_axis_tuser), 32'(exp_q[0].u));
         chk("tlast", 32'(m_axis_tlast), 32'(exp_q[0].l));
      end
      if (m_just_reset) begin
         chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
         chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
         chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
      end
      chk("frame_count", 32'(frame_count), 32'(m_fc));
      chk("overrun", 32'(overrun), 32'(m_ovr));
   endtask

   task automatic step();
      @(posedge aclk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      // Continuous mode, always-ready consumer.
      do_reset();
      chk("reset_fc", 32'(frame_count), 32'd0);
      data_in = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      mode = 2'd0;
      repeat (10) step();
      chk("cont_fc", 32'(frame_count), 32'd2);

      // Stall on beat 2 while the inputs change underneath.
      for (int i = 0; i < 20 && !(m_axis_tvalid && m_axis_tuser == 2'd2); i++) step();
      chk("reach_beat2", 32'(m_axis_tvalid && m_axis_tuser == 2'd2), 32'd1);
      m_axis_tready = 1'b0;
      data_in = 64'h1111_2222_3333_4444;
      repeat (5) step();
      chk("stall_tdata", 32'(m_axis_tdata), 32'h0003);
      chk("stall_tuser", 32'(m_axis_tuser), 32'd2);
      m_axis_tready = 1'b1;
      mode = 2'd3;
      repeat (10) step();

      // On-change mode.
      mode = 2'd1;
      data_in = '0;
      do_reset();
      repeat (15) step();
      chk("chg_first_fc", 32'(frame_count), 32'd1);
      data_in[63:48] = 16'hBEEF;
      repeat (15) step();
      chk("chg_second_fc", 32'(frame_count), 32'd2);

      // Trigger mode: pending and overrun.
      mode = 2'd2;
      do_reset();
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      chk("trig_tvalid", 32'(m_axis_tvalid), 32'd1);
      step();
      trigger = 1'b1;
      step();
      step();
      trigger = 1'b0;
      repeat (9) step();
      chk("trig_fc", 32'(frame_count), 32'd2);
      chk("trig_overrun", 32'(overrun), 32'd1);

      // Disabled mode, then a mode change in mid-frame.
      mode = 2'd3;
      repeat (100) step();
      chk("off_overrun_sticky", 32'(overrun), 32'd1);
      mode = 2'd2;
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      step();
      mode = 2'd0;
      repeat (12) step();
      mode = 2'd3;
      repeat (10) step();

      // Reset while stalled on beat 1.
      mode = 2'd1;
      data_in = 64'hDEAD_0000_CAFE_1234;
      for (int i = 0; i < 20 && !(m_axis_tvalid && m_axis_tuser == 2'd1); i++) step();
      chk("reach_beat1", 32'(m_axis_tvalid && m_axis_tuser == 2'd1), 32'd1);
      m_axis_tready = 1'b0;
      step();
      reset = 1'b1;
      step();
      chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("midrst_fc", 32'(frame_count), 32'd0);
      chk("midrst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      m_axis_tready = 1'b1;
      step();
      chk("post_rst_launch", 32'(m_axis_tvalid), 32'd1);

      // Randomised traffic.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
         trigger = ($urandom_range(0, 9) == 0);
         m_axis_tready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0)
            data_in[$urandom_range(0, 3)*16 +: 16] = 16'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
